// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder: one fill or writeback at a time, fixed latency,
// full-line response over a valid/ready handshake.
module line_mem_responder #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned LATENCY     = 5,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [31:0]               req_addr_i,
  input  logic [32*LINE_WORDS-1:0]  req_wdata_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic                      resp_write_o,
  output logic [32*LINE_WORDS-1:0]  resp_rdata_o
);

  localparam int unsigned LineBits = 32 * LINE_WORDS;
  localparam int unsigned OffBits  = $clog2(LINE_WORDS * 4);
  localparam int unsigned NumLines = DEPTH_WORDS / LINE_WORDS;
  localparam int unsigned IdxBits  = (NumLines > 1) ? $clog2(NumLines) : 1;
  localparam int unsigned CntBits  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned CntInit  = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               state_q;
  logic [CntBits-1:0]   cnt_q;
  logic                 write_q;
  logic [IdxBits-1:0]   idx_q;
  logic [LineBits-1:0]  wdata_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 resp_write_q;
  logic [LineBits-1:0]  resp_rdata_q;

  logic [LineBits-1:0]  mem_q [NumLines];

  logic                 accept;
  logic [IdxBits-1:0]   req_idx;
  logic                 mem_we;
  logic [IdxBits-1:0]   mem_widx;
  logic [LineBits-1:0]  mem_wdata;
  logic                 unused_addr;

  assign accept      = req_valid_i && req_ready_q;
  assign unused_addr = ^req_addr_i;

  // Addresses past the array wrap by simply dropping the upper bits.
  if (NumLines > 1) begin : g_idx
    assign req_idx = req_addr_i[OffBits +: IdxBits];
  end else begin : g_idx_single
    assign req_idx = '0;
  end

  // Writes commit on the transition into StResp; an abort by reset never commits.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = wdata_q;
    if (state_q == StIdle && accept && LATENCY == 1) begin
      mem_we    = req_write_i;
      mem_widx  = req_idx;
      mem_wdata = req_wdata_i;
    end else if (state_q == StWait && cnt_q == '0) begin
      mem_we = write_q;
    end
    if (reset_i) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write_i;
            idx_q       <= req_idx;
            wdata_q     <= req_wdata_i;
            if (LATENCY == 1) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_write_q <= req_write_i;
              resp_rdata_q <= req_write_i ? '0 : mem_q[req_idx];
            end else begin
              state_q <= StWait;
              cnt_q   <= CntBits'(CntInit);
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_write_q <= write_q;
            resp_rdata_q <= write_q ? '0 : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          // Ready rises right after the handshake, leaving one idle cycle between responses.
          if (resp_ready_i) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_write_o = resp_write_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Randomized bench for line_mem_responder against a line-array reference model,
// plus a LATENCY=1 instance for the short-latency path.
module tb_line_mem_responder;

  localparam int unsigned Lat     = 5;
  localparam int unsigned NLines  = 1024;
  localparam int unsigned NLines1 = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic         resp_write;
  logic [127:0] resp_rdata;

  logic         req_valid1 = 1'b0;
  logic         req_ready1;
  logic         req_write1 = 1'b0;
  logic [31:0]  req_addr1 = '0;
  logic [127:0] req_wdata1 = '0;
  logic         resp_valid1;
  logic         resp_ready1 = 1'b0;
  logic         resp_write1;
  logic [127:0] resp_rdata1;

  int n_total = 0;
  int n_bad   = 0;

  logic [127:0] ref_mem [NLines];
  logic [127:0] ref1 [NLines1];

  always #5 clk = ~clk;

  line_mem_responder #(.LINE_WORDS(4), .LATENCY(Lat), .DEPTH_WORDS(4096)) u_dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_write_o (resp_write),
    .resp_rdata_o (resp_rdata)
  );

  line_mem_responder #(.LINE_WORDS(4), .LATENCY(1), .DEPTH_WORDS(64)) u_dut1 (
    .clk_i        (clk),
    .reset_i      (rst),
    .req_valid_i  (req_valid1),
    .req_ready_o  (req_ready1),
    .req_write_i  (req_write1),
    .req_addr_i   (req_addr1),
    .req_wdata_i  (req_wdata1),
    .resp_valid_o (resp_valid1),
    .resp_ready_i (resp_ready1),
    .resp_write_o (resp_write1),
    .resp_rdata_o (resp_rdata1)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction on the main instance; called and returns at a negedge.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [127:0] wdata, input int stall);
    int unsigned  idx;
    logic [127:0] exp;
    int           lat;
    int           guard;
    logic         ready_seen;
    logic         stable_ok;
    idx   = (addr >> 4) % NLines;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = rnd128();
    lat        = 1;
    ready_seen = 1'b0;
    while (!resp_valid && lat < 50) begin
      if (req_ready) ready_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (wr) begin
      ref_mem[idx] = wdata;
      exp = '0;
    end else begin
      exp = ref_mem[idx];
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'(Lat));
    check_eq({tag, "_busy"}, ready_seen, 1'b0);
    check_eq({tag, "_wr"}, resp_write, wr);
    check_eq({tag, "_data"}, resp_rdata, exp);
    stable_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      @(negedge clk);
      if (!resp_valid || resp_rdata !== exp || resp_write !== wr || req_ready) stable_ok = 1'b0;
    end
    req_valid = 1'b0;
    check_eq({tag, "_hold"}, stable_ok, 1'b1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq({tag, "_vfall"}, resp_valid, 1'b0);
    check_eq({tag, "_rdy"}, req_ready, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] old;
    logic         stayed_low;
    int unsigned  k;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_valid", resp_valid, 1'b0);
    check_eq("rst_write", resp_write, 1'b0);
    check_eq("rst_rdata", resp_rdata, '0);
    check_eq("rst1_ready", req_ready1, 1'b0);
    check_eq("rst1_valid", resp_valid1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", req_ready, 1'b1);

    // Give every line known contents so reads have a defined expectation.
    for (int i = 0; i < int'(NLines); i++) begin
      do_req("pre", 1'b1, 32'(i) << 4, rnd128(), 0);
    end

    do_req("rd40", 1'b0, 32'h40, '0, 0);
    do_req("wr100", 1'b1, 32'h100, {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, 0);
    do_req("rd10c", 1'b0, 32'h10C, '0, 0);
    check_eq("rd10c_model", ref_mem[16],
             {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000});
    do_req("bp", 1'b0, 32'h80, '0, 7);
    do_req("wrap_w", 1'b1, 32'h4000, rnd128(), 0);
    do_req("wrap_r", 1'b0, 32'h0, '0, 0);

    // Reset during WAIT of a write: nothing commits, nothing responds.
    old       = ref_mem[32];
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h200;
    req_wdata = {4{32'h11111111}};
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", req_ready, 1'b0);
    check_eq("abort_valid", resp_valid, 1'b0);
    rst = 1'b0;
    stayed_low = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) stayed_low = 1'b0;
    end
    check_eq("abort_noresp", stayed_low, 1'b1);
    do_req("abort_rd", 1'b0, 32'h200, '0, 0);
    check_eq("abort_model", ref_mem[32], old);

    for (int i = 0; i < 300; i++) begin
      do_req("rand", 1'($urandom), $urandom, rnd128(), int'($urandom_range(0, 3)));
    end

    // LATENCY=1 instance: request held continuously, handshake every response.
    resp_ready1 = 1'b1;
    for (int i = 0; i < 2 * int'(NLines1); i++) begin
      check_eq("l1_ready", req_ready1, 1'b1);
      if (i < int'(NLines1)) begin
        k          = 32'(i);
        ref1[k]    = rnd128();
        req_write1 = 1'b1;
        req_wdata1 = ref1[k];
      end else begin
        k          = $urandom_range(0, NLines1 - 1);
        req_write1 = 1'b0;
        req_wdata1 = rnd128();
      end
      req_addr1  = {$urandom_range(0, 255), 4'(k), 4'($urandom)};
      req_valid1 = 1'b1;
      @(negedge clk);
      check_eq("l1_valid", resp_valid1, 1'b1);
      check_eq("l1_wr", resp_write1, req_write1);
      check_eq("l1_data", resp_rdata1, req_write1 ? 128'h0 : ref1[k]);
      req_addr1 = $urandom;
      @(negedge clk);
      check_eq("l1_vfall", resp_valid1, 1'b0);
    end
    req_valid1  = 1'b0;
    resp_ready1 = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
